// File: rtl/module_gate_ctrl.sv
// Module-side gate controller: UART command decode, shadowed pattern,
// shoot-synchronised dead-time sequencing, watchdog and ACK/NAK replies.
module module_gate_ctrl #(
  parameter int         DEAD_CYCLES = 48,
  parameter int         WDOG_CYCLES = 4800000,
  parameter logic [7:0] ACK_BYTE    = 8'hA5,
  parameter logic [7:0] NAK_BYTE    = 8'h5A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_received,
  input  logic       rx_done,
  input  logic       parity_error,
  input  logic       shoot,
  input  logic       tx_busy,
  output logic [7:0] data_to_tx,
  output logic       start_tx,
  output logic [2:0] gate_h,
  output logic [2:0] gate_l,
  output logic       armed,
  output logic       fault
);

  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  // Loading N-1 and leaving at zero yields exactly N all-off cycles.
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

  typedef enum logic [1:0] {
    SAFE,
    DEAD,
    DRIVE,
    FAULT
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_n;
  logic [WW-1:0] wcnt;
  logic [WW-1:0] wcnt_n;
  logic [5:0]    shadow;
  logic [5:0]    active;
  logic [5:0]    active_n;
  logic          trip;

  logic [2:0]    sh_sync;
  logic          edge_q;

  logic [1:0]    cmd;
  logic          rx_bad;
  logic          rx_ok;
  logic          is_load;
  logic          is_ping;
  logic          is_disarm;
  logic          is_ill;

  logic          pend;
  logic [7:0]    pend_byte;
  logic          reply_vld;
  logic [7:0]    reply_byte;

  assign cmd       = data_received[7:6];
  assign rx_bad    = rx_done & parity_error;
  assign rx_ok     = rx_done & ~parity_error;
  assign is_load   = rx_ok & (cmd == 2'b00);
  assign is_ping   = rx_ok & (cmd == 2'b01);
  assign is_disarm = rx_ok & (cmd == 2'b10);
  assign is_ill    = rx_ok & (cmd == 2'b11);

  assign gate_h = (state == DRIVE) ?
                  (active[5:3] & active[2:0]) : 3'b000;
  assign gate_l = (state == DRIVE) ?
                  (active[5:3] & ~active[2:0]) : 3'b000;

  // Synchronise the shoot pin and register a one-cycle rising-edge pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_sync <= 3'b000;
      edge_q  <= 1'b0;
    end else begin
      sh_sync <= {sh_sync[1:0], shoot};
      edge_q  <= sh_sync[1] & ~sh_sync[2];
    end
  end

  // Next-state, dead-time and watchdog counter logic.
  always_comb begin
    state_n  = state;
    dcnt_n   = dcnt;
    wcnt_n   = wcnt;
    active_n = active;
    trip     = 1'b0;
    unique case (state)
      SAFE: begin
        if (edge_q && armed) begin
          state_n = DEAD;
          dcnt_n  = DEAD_LOAD;
        end
      end
      DEAD: begin
        if (edge_q) begin
          dcnt_n = DEAD_LOAD;
        end else if (dcnt == '0) begin
          state_n  = DRIVE;
          active_n = shadow;
          wcnt_n   = '0;
        end else begin
          dcnt_n = dcnt - 1'b1;
        end
      end
      DRIVE: begin
        if (edge_q) begin
          if (shadow != active) begin
            state_n = DEAD;
            dcnt_n  = DEAD_LOAD;
          end else begin
            wcnt_n = '0;
          end
        end else if (wcnt == WDOG_LAST) begin
          state_n = FAULT;
          trip    = 1'b1;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
      end
      FAULT: begin
        state_n = FAULT;
      end
      default: state_n = SAFE;
    endcase
    if (is_disarm) begin
      state_n = SAFE;
      trip    = 1'b0;
    end
  end

  // Select the reply for this cycle; DISARM and a watchdog trip take priority.
  always_comb begin
    reply_vld  = 1'b0;
    reply_byte = ACK_BYTE;
    unique case (1'b1)
      rx_bad:    begin reply_vld = 1'b1; reply_byte = NAK_BYTE; end
      is_load:   begin
        reply_vld  = 1'b1;
        reply_byte = fault ? NAK_BYTE : ACK_BYTE;
      end
      is_ping:   begin reply_vld = 1'b1; reply_byte = ACK_BYTE; end
      is_disarm: begin reply_vld = 1'b1; reply_byte = ACK_BYTE; end
      is_ill:    begin reply_vld = 1'b1; reply_byte = NAK_BYTE; end
      default:   begin reply_vld = 1'b0; reply_byte = ACK_BYTE; end
    endcase
    if (trip) begin
      reply_vld  = 1'b1;
      reply_byte = NAK_BYTE;
    end
  end

  // FSM state and sequencing counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= SAFE;
      dcnt   <= '0;
      wcnt   <= '0;
      active <= 6'd0;
    end else begin
      state  <= state_n;
      dcnt   <= dcnt_n;
      wcnt   <= wcnt_n;
      active <= active_n;
    end
  end

  // Shadow pattern, armed and latched fault flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= 6'd0;
      armed  <= 1'b0;
      fault  <= 1'b0;
    end else begin
      if (is_load && !fault) begin
        shadow <= data_received[5:0];
        armed  <= 1'b1;
      end
      if (trip) begin
        armed <= 1'b0;
        fault <= 1'b1;
      end
      if (is_disarm) begin
        armed <= 1'b0;
        fault <= 1'b0;
      end
    end
  end

  // Single pending reply slot; a newer reply overwrites an unsent one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend       <= 1'b0;
      pend_byte  <= 8'd0;
      start_tx   <= 1'b0;
      data_to_tx <= 8'd0;
    end else begin
      start_tx <= 1'b0;
      if (pend && !tx_busy) begin
        start_tx   <= 1'b1;
        data_to_tx <= pend_byte;
        pend       <= 1'b0;
      end
      if (reply_vld) begin
        pend      <= 1'b1;
        pend_byte <= reply_byte;
      end
    end
  end

endmodule

// File: tb/tb_module_gate_ctrl.sv
// Bench for module_gate_ctrl: reply scoreboard, dead-time timing,
// watchdog trip, command/shoot collision and asynchronous reset.
module tb_module_gate_ctrl;

  localparam int WD = 1000;
  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'h5A;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_received;
  logic       rx_done;
  logic       parity_error;
  logic       shoot;
  logic       tx_busy;
  logic [7:0] data_to_tx;
  logic       start_tx;
  logic [2:0] gate_h;
  logic [2:0] gate_l;
  logic       armed;
  logic       fault;

  int         checks = 0;
  int         errors = 0;
  int         ovl = 0;
  logic [7:0] exp_q[$];

  int         first;
  int         zeros;
  logic [5:0] g3;
  logic [5:0] g4;

  always #5 clk = ~clk;

  module_gate_ctrl #(
    .DEAD_CYCLES(48),
    .WDOG_CYCLES(WD),
    .ACK_BYTE(ACK),
    .NAK_BYTE(NAK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .data_received(data_received),
    .rx_done(rx_done),
    .parity_error(parity_error),
    .shoot(shoot),
    .tx_busy(tx_busy),
    .data_to_tx(data_to_tx),
    .start_tx(start_tx),
    .gate_h(gate_h),
    .gate_l(gate_l),
    .armed(armed),
    .fault(fault)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if ((gate_h & gate_l) != 3'b000) ovl++;
    if (start_tx) begin
      chk("tx_q", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("tx_byte", int'(data_to_tx), int'(exp_q.pop_front()));
    end
  end

  task automatic send(input logic [7:0] b, input logic pe,
                      input logic [7:0] rep, input logic push);
    @(negedge clk);
    data_received = b;
    parity_error  = pe;
    rx_done       = 1'b1;
    if (push) exp_q.push_back(rep);
    @(negedge clk);
    rx_done      = 1'b0;
    parity_error = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic measure(input logic [5:0] exp, output int f,
                         output int z, output logic [5:0] s3,
                         output logic [5:0] s4);
    f  = 0;
    z  = 0;
    s3 = 6'd0;
    s4 = 6'd0;
    @(negedge clk);
    shoot = 1'b1;
    for (int n = 1; n <= 70; n++) begin
      @(posedge clk);
      #1;
      if (n == 4) shoot = 1'b0;
      if ({gate_h, gate_l} == 6'd0) z++;
      if (f == 0 && {gate_h, gate_l} == exp) f = n;
      if (n == 3) s3 = {gate_h, gate_l};
      if (n == 4) s4 = {gate_h, gate_l};
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    data_received = 8'h00;
    rx_done       = 1'b0;
    parity_error  = 1'b0;
    shoot         = 1'b0;
    tx_busy       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gates", int'({gate_h, gate_l}), 0);
    chk("rst_start", int'(start_tx), 0);
    chk("rst_data", int'(data_to_tx), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_fault", int'(fault), 0);
    @(negedge clk);
    reset = 1'b0;

    send(8'h3D, 1'b0, ACK, 1'b1);
    drain("load_ack");
    chk("load_armed", int'(armed), 1);
    measure(6'b101010, first, zeros, g3, g4);
    chk("t1_first", first, 52);
    chk("t1_zeros", zeros, 51);

    measure(6'b101010, first, zeros, g3, g4);
    chk("t2_first", first, 1);
    chk("t2_zeros", zeros, 0);

    send(8'h1A, 1'b1, NAK, 1'b1);
    drain("par_nak");
    measure(6'b101010, first, zeros, g3, g4);
    chk("par_first", first, 1);
    chk("par_zeros", zeros, 0);

    tx_busy = 1'b1;
    send(8'h40, 1'b0, ACK, 1'b0);
    send(8'hC0, 1'b0, NAK, 1'b1);
    repeat (5) @(negedge clk);
    chk("busy_hold", exp_q.size(), 1);
    tx_busy = 1'b0;
    drain("latest_nak");

    send(8'h1A, 1'b0, ACK, 1'b1);
    drain("load2_ack");
    measure(6'b010001, first, zeros, g3, g4);
    chk("sw_g3", int'(g3), int'(6'b101010));
    chk("sw_g4", int'(g4), 0);
    chk("sw_first", first, 52);
    chk("sw_zeros", zeros, 48);

    @(negedge clk);
    shoot = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    data_received = 8'h07;
    rx_done       = 1'b1;
    exp_q.push_back(ACK);
    @(negedge clk);
    rx_done = 1'b0;
    shoot   = 1'b0;
    repeat (3) @(negedge clk);
    chk("coinc_old", int'({gate_h, gate_l}), int'(6'b010001));
    drain("coinc_ack");
    measure(6'b000000, first, zeros, g3, g4);
    chk("coinc_g3", int'(g3), int'(6'b010001));
    chk("coinc_first", first, 4);
    chk("coinc_zeros", zeros, 67);
    chk("coinc_armed", int'(armed), 1);

    exp_q.push_back(NAK);
    repeat (WD - 100) @(negedge clk);
    chk("wd_early", int'(fault), 0);
    for (int n = 0; n < 300 && !fault; n++) @(negedge clk);
    chk("wd_trip", int'(fault), 1);
    chk("wd_armed", int'(armed), 0);
    chk("wd_gates", int'({gate_h, gate_l}), 0);
    drain("wd_nak");
    send(8'h3D, 1'b0, NAK, 1'b1);
    drain("flt_load_nak");
    chk("flt_hold", int'(fault), 1);
    send(8'h80, 1'b0, ACK, 1'b1);
    drain("disarm_ack");
    chk("disarm_fault", int'(fault), 0);
    chk("disarm_armed", int'(armed), 0);
    send(8'h40, 1'b0, ACK, 1'b1);
    drain("ping_ack");
    measure(6'b101010, first, zeros, g3, g4);
    chk("unarmed_zeros", zeros, 70);

    send(8'h3D, 1'b0, ACK, 1'b1);
    drain("rl_ack");
    @(negedge clk);
    shoot = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rdead_gates", int'({gate_h, gate_l}), 0);
    chk("rdead_start", int'(start_tx), 0);
    chk("rdead_armed", int'(armed), 0);
    shoot = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    send(8'h3D, 1'b0, ACK, 1'b1);
    drain("rl2_ack");
    measure(6'b101010, first, zeros, g3, g4);
    chk("pre_rst", int'({gate_h, gate_l}), int'(6'b101010));
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rdrv_gates", int'({gate_h, gate_l}), 0);
    chk("rdrv_start", int'(start_tx), 0);
    chk("rdrv_data", int'(data_to_tx), 0);
    chk("rdrv_armed", int'(armed), 0);
    @(negedge clk);
    reset = 1'b0;
    measure(6'b101010, first, zeros, g3, g4);
    chk("post_rst_safe", zeros, 70);

    chk("overlap", ovl, 0);
    chk("q_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
